fs_seq_arbiter: RTL and testbench

FS_SEQ_ARBITER -- requirements
Module: fs_seq_arbiter

---
 rtl/fs_seq_arbiter.sv | 147 ++++++++++++++
 tb/tb_fs_seq_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fs_seq_arbiter.sv
// Two-requester round-robin front end for a nibble-serial subtractor.
// One nibble of a - b - bin is resolved per cycle, LSB first, with the borrow carried in a flop.
module fs_seq_arbiter #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [4*NIB-1:0] a0,
  input  logic [4*NIB-1:0] b0,
  input  logic             bin0,
  input  logic             req1,
  input  logic [4*NIB-1:0] a1,
  input  logic [4*NIB-1:0] b1,
  input  logic             bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [4*NIB-1:0] diff,
  output logic             bout
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brw_q, brw_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            ptr_q, ptr_d;   // requester that wins a tie
  logic            win_q, win_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            owner_q, owner_d, bout_q, bout_d;
  logic [W-1:0]    diff_q, diff_d;

  logic            win;
  logic [4:0]      nib_t;

  assign win   = (req0 && req1) ? ptr_q : req1;
  assign nib_t = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - 5'(brw_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    owner_d = owner_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = win;
          ptr_d   = ~win;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          brw_d   = win ? bin1 : bin0;
          cnt_d   = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        brw_d = nib_t[4];
        // New nibble enters at the top; after NIB steps the LSB nibble has reached bit 0.
        res_d = W'({nib_t[3:0], res_q} >> 4);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          diff_d  = res_d;
          bout_d  = nib_t[4];
          owner_d = win_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_fs_seq_arbiter.sv
// Directed bench for fs_seq_arbiter (NIB=4): arithmetic, latency, round-robin order, reset abort.
module tb_fs_seq_arbiter;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, bin0 = 1'b0, bin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, owner, bout;
  logic [W-1:0] diff;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  fs_seq_arbiter #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .bin0(bin0),
    .req1(req1), .a1(a1), .b1(b1), .bin1(bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Issue one request from a negedge and gather what the DUT shows; callers compare.
  task automatic run_op(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, output logic g0, output logic g1, output int lat,
                        output logic [W-1:0] d, output logic bo, output logic ow,
                        output logic held, output logic dnext);
    logic [W-1:0] pre;
    pre = diff;
    if (r) begin req1 = 1'b1; a1 = a; b1 = b; bin1 = bin; end
    else   begin req0 = 1'b1; a0 = a; b0 = b; bin0 = bin; end
    @(posedge clk); @(negedge clk);
    g0 = gnt0; g1 = gnt1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    lat = 0; held = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (diff !== pre) held = 1'b0;
      lat++;
      @(negedge clk);
    end
    d = diff; bo = bout; ow = owner;
    @(negedge clk);
    dnext = done;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({gnt0, gnt1, busy, done} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {gnt0, gnt1, busy, done}); end
    checks++; if ({owner, bout, diff} !== '0) begin errors++;
      $display("FAIL reset_data: owner=%b bout=%b diff=%h want all 0", owner, bout, diff); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic g0, g1, bo, ow, held, dn; int lat; logic [W-1:0] d;
    run_op(1'b0, 16'h1234, 16'h0234, 1'b0, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if ({g0, g1} !== 2'b10) begin errors++; $display("FAIL basic_gnt: got %b want 10", {g0, g1}); end
    checks++; if (lat !== NIB) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, NIB); end
    checks++; if (d !== 16'h1000) begin errors++; $display("FAIL basic_diff: got %h want 1000", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b want 0", bo); end
    checks++; if (ow !== 1'b0) begin errors++; $display("FAIL basic_owner: got %b want 0", ow); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_no_partial: diff changed before done"); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done still %b a cycle later", dn); end
    repeat (3) @(negedge clk);
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_hold: got %h want 1000", diff); end
  endtask

  task automatic test_req1();
    logic g0, g1, bo, ow, held, dn; int lat; logic [W-1:0] d;
    run_op(1'b1, 16'h0000, 16'h0001, 1'b0, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL req1_gnt: got %b want 01", {g0, g1}); end
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL req1_diff: got %h want ffff", d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL req1_bout: got %b want 1", bo); end
    checks++; if (ow !== 1'b1) begin errors++; $display("FAIL req1_owner: got %b want 1", ow); end
  endtask

  task automatic test_ripple();
    logic g0, g1, bo, ow, held, dn; int lat; logic [W-1:0] d;
    run_op(1'b0, 16'h8000, 16'h7FFF, 1'b1, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ripple_diff: got %h want 0000", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL ripple_bout: got %b want 0", bo); end
    // 0 - FFFF - 1 wraps to exactly 0 with a borrow out.
    run_op(1'b0, 16'h0000, 16'hFFFF, 1'b1, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if ({bo, d} !== 17'h10000) begin errors++; $display("FAIL wrap_max: got bout=%b diff=%h want 1/0000", bo, d); end
    run_op(1'b1, 16'hA5C3, 16'h1E2F, 1'b0, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if ({bo, d} !== 17'h08794) begin errors++; $display("FAIL mixed: got bout=%b diff=%h want 0/8794", bo, d); end
  endtask

  task automatic test_back_to_back();
    int t[4]; logic who[4]; int n; logic both;
    @(negedge clk); rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; a0 = 16'h0009; b0 = 16'h0001; a1 = 16'h0002; b1 = 16'h0003;
    @(negedge clk); rst = 1'b0;
    n = 0; both = 1'b0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both = 1'b1;
      if (gnt0 || gnt1) begin t[n] = cyc; who[n] = gnt1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d grants want 4", n); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_both: gnt0 and gnt1 high together"); end
    if (n == 4) begin
      checks++; if ({who[0], who[1], who[2], who[3]} !== 4'b0101) begin errors++;
        $display("FAIL rr_order: got %b want 0101", {who[0], who[1], who[2], who[3]}); end
      for (int k = 1; k < 4; k++) begin
        checks++; if (t[k] - t[k-1] !== NIB + 2) begin errors++;
          $display("FAIL rr_spacing%0d: got %0d want %0d", k, t[k] - t[k-1], NIB + 2); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic g0, g1, bo, ow, held, dn, saw; int lat; logic [W-1:0] d;
    do_reset();
    run_op(1'b1, 16'h0000, 16'h0001, 1'b0, g0, g1, lat, d, bo, ow, held, dn);
    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0001; bin0 = 1'b0;
    @(posedge clk); @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({gnt0, gnt1, busy, done, owner, bout, diff} !== '0) begin errors++;
      $display("FAIL abort_clear: gnt=%b%b busy=%b done=%b owner=%b bout=%b diff=%h want all 0",
               gnt0, gnt1, busy, done, owner, bout, diff); end
    @(negedge clk); rst = 1'b0;
    saw = 1'b0;
    repeat (10) begin @(negedge clk); if (done) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_done: done pulsed after abort"); end
    run_op(1'b0, 16'h0005, 16'h0003, 1'b0, g0, g1, lat, d, bo, ow, held, dn);
    checks++; if (g0 !== 1'b1) begin errors++; $display("FAIL abort_regrant: got %b want 1", g0); end
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL abort_diff: got %h want 0002", d); end
  endtask

  task automatic test_ignore_busy();
    logic saw_g1; int k;
    do_reset();
    req0 = 1'b1; a0 = 16'h4321; b0 = 16'h1111; bin0 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL ign_gnt0: got %b want 1", gnt0); end
    req0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0000; b1 = 16'hFFFF; bin1 = 1'b1;
    saw_g1 = 1'b0;
    @(negedge clk);
    req1 = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      if (gnt1) saw_g1 = 1'b1;
      k++; @(negedge clk);
    end
    checks++; if ({done, owner, bout, diff} !== {3'b100, 16'h3210}) begin errors++;
      $display("FAIL ign_result: done=%b owner=%b bout=%b diff=%h want 1/0/0/3210", done, owner, bout, diff); end
    repeat (6) begin @(negedge clk); if (gnt1) saw_g1 = 1'b1; end
    checks++; if (saw_g1 !== 1'b0) begin errors++; $display("FAIL ign_gnt1: gnt1 pulsed for a request made while busy"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req1();
    test_ripple();
    test_back_to_back();
    test_reset_abort();
    test_ignore_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
